apb_i2c_regs: RTL and testbench
===============================

// Module: apb_i2c_regs
// PURPOSE
// - APB slave stage directly downstream of the APB master; terminates sel/enable/write/addr/wdata, returns rdata/ready.
// - Register file + 4-deep TX/RX byte FIFOs + command handshake to the I2C byte engine (external block).
// - Inserts APB wait states (ready low) on TX-full writes and on CMD writes while a transfer is pending.
// PARAMETERS
// - SLAVE_ID    2'b01  sel value that selects this slave
// - ADDR_W      8      APB address width
// - DATA_W      8      APB data width (register and FIFO byte width)
// - FIFO_DEPTH  4      TX and RX FIFO entries (power of 2, >=2)
// PORTS
// - clk          in   1        system clock
// - reset_n      in   1        asynchronous, active-low reset
// - sel          in   2        APB slave select; active when == SLAVE_ID
// - enable       in   1        APB access phase
// - write        in   1        1 = write, 0 = read
// - addr         in   ADDR_W   register address
// - wdata        in   DATA_W   write data
// - rdata        out  DATA_W   read data, valid while ready=1 in access phase
// - ready        out  1        transfer completes on a clk edge where sel match & enable & ready
// - cmd_valid    out  1        command to I2C engine, held until cmd_ready
// - cmd_ready    in   1        engine accepts command
// - cmd_addr     out  7        I2C target address
// - cmd_rw       out  1        1 = I2C read
// - cmd_len      out  4        byte count, 1..15
// - tx_data      out  8        TX FIFO head
// - tx_valid     out  1        TX FIFO not empty
// - tx_ready     in   1        engine pops TX head when tx_valid & tx_ready
// - rx_data      in   8        received byte
// - rx_valid     in   1        one-cycle strobe, no backpressure
// - done         in   1        one-cycle pulse, transfer finished
// - nack         in   1        one-cycle pulse, target NACKed
// BEHAVIOUR
// - Reset: ready=0, rdata=0, cmd_valid=0, busy=0, FIFOs empty, SADDR=0, all sticky bits 0; takes effect mid-transfer, no completion.
// - APB FSM: IDLE -> SETUP (sel match & !enable; latch addr/write/wdata) -> ACCESS (enable); ready=1 in the first ACCESS cycle unless stalled.
// - Write to STATUS/SADDR/unmapped addresses and reads of any address: zero wait states.
// - Stall (ready=0 in ACCESS, repeated each cycle): TXDATA write while TX full; CMD write while cmd_valid|busy.
// - Side effects occur only on the completion edge, once per transfer.
// - Register map:
//   0x0 SADDR  rw  [6:0] target address, [7] rw bit
//   0x1 TXDATA wo  push wdata to TX FIFO; reads return 0
//   0x2 RXDATA ro  pop RX head; if empty return 0x00 and set rx_underflow
//   0x3 STATUS ro  [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty [4] busy
//                  [5] rx_underflow [6] nack_seen [7] rx_overflow; write 1 clears [7:5]
//   0x4 CMD    wo  wdata[3:0]=len; len 0 ignored (no stall, no cmd); else cmd_valid=1 with SADDR fields
//   others: writes ignored, reads 0
// - Command: busy set on cmd_valid & cmd_ready edge (cmd_valid drops same edge); busy clears on done.
// - done while not busy is ignored; nack sets nack_seen regardless of busy.
// - FIFOs: simultaneous push and pop both occur, count unchanged; pointers wrap at FIFO_DEPTH.
// - RX full & rx_valid: byte dropped, rx_overflow set; RX pop and rx_valid on the same edge when full: both accepted.
// - STATUS W1C and a same-cycle set event: set wins.
// CONFIGURATION
// - APB_I2C_IRQ_EN defined: adds port irq (out, 1) and register 0x5 IER rw [0] done_ie [1] nack_ie [2] rx_ie.
//   - done_flag is a sticky internal bit set by done; STATUS write to bit 4 clears it.
//   - irq = registered OR of (done_flag & done_ie) | (nack_seen & nack_ie) | (!rx_empty & rx_ie).
//   - irq, IER and done_flag reset to 0.
// - APB_I2C_IRQ_EN undefined: no irq port; 0x5 behaves as unmapped.
// TESTING
// - Reset, then SADDR=0x51 write and readback -> rdata=0x51, ready high in first ACCESS cycle.
// - 5 TXDATA writes 0xA0..0xA4, tx_ready=0 -> 5th write stalls; tx_ready pulse -> stall ends, tx_data=0xA1.
// - CMD len=3 with SADDR=0xA2 -> cmd_valid, cmd_addr=0x22, cmd_rw=1, cmd_len=3.
//   Second CMD write stalls until done, then is issued.
// - Six rx_valid bytes 0x10..0x15 with no reads -> RXDATA reads 0x10..0x13, rx_overflow=1.
//   A further read returns 0x00 and sets rx_underflow; STATUS write 0xE0 clears [7:5].
// - nack pulse coincident with STATUS write 0x40 -> nack_seen stays 1.
//   reset_n low during a CMD stall -> ready=0, cmd_valid=0, FIFOs empty.
// - APB_I2C_IRQ_EN: IER=0x01, done pulse after command -> irq=1 next cycle; STATUS write 0x10 -> irq=0.

Source files
------------

// File: rtl/apb_i2c_regs_if.sv
// APB bus bundle between the APB master and the I2C register slave.
//   sel/enable/write/addr/wdata : master -> slave request
//   rdata/ready                 : slave -> master response
interface apb_i2c_regs_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [1:0]        sel;
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output sel, enable, write, addr, wdata, input rdata, ready);
  modport slave  (input sel, enable, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/apb_i2c_regs.sv
// APB register slave for an I2C byte engine.
// Register file, 4-deep TX/RX byte FIFOs and the command handshake to the
// external engine. Inserts wait states on TXDATA writes while TX is full
// and on CMD writes while a command is pending or the engine is busy.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   apb (slave)      sel/enable/write/addr/wdata in, rdata/ready out
//   cmd_*            command to engine (valid/ready), addr/rw/len fields
//   tx_data/valid/ready  TX FIFO head towards engine
//   rx_data/valid    received byte strobe (no backpressure)
//   done, nack       engine event pulses
//   irq              only with APB_I2C_IRQ_EN defined
// Optional feature macro: APB_I2C_IRQ_EN (IER register at 0x5 + irq output).
module apb_i2c_regs #(
  parameter logic [1:0] SLAVE_ID   = 2'b01,
  parameter int         ADDR_W     = 8,
  parameter int         DATA_W     = 8,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  apb_i2c_regs_if.slave     apb,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [6:0]        cmd_addr,
  output logic              cmd_rw,
  output logic [3:0]        cmd_len,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              done,
  input  logic              nack
`ifdef APB_I2C_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [ADDR_W-1:0] A_SADDR  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(4);
`ifdef APB_I2C_IRQ_EN
  localparam logic [ADDR_W-1:0] A_IER    = ADDR_W'(5);
`endif

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;

  logic              sel_hit, ready_c, stall, xfer;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_val;

  logic [7:0] saddr;
  logic       busy, rx_unf, nack_seen, rx_ovf;
  logic       rx_unf_d, nack_d, rx_ovf_d;

  // FIFO state
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
  logic [PW:0]       tx_cnt, rx_cnt, tx_cnt_d, rx_cnt_d;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              is_tx_wr, is_cmd_wr, sts_wr, rx_rd;

  assign sel_hit   = (apb.sel == SLAVE_ID);
  assign is_tx_wr  = wr_q && (addr_q == A_TXDATA);
  // len 0 is a no-op: no stall and no command
  assign is_cmd_wr = wr_q && (addr_q == A_CMD) && (wdata_q[3:0] != 4'd0);
  assign stall     = (is_tx_wr && tx_full) || (is_cmd_wr && (cmd_valid || busy));

  // ---------------- APB FSM ----------------
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  // SETUP/ACCESS share completion logic: ready is offered on the first
  // enable cycle unless stalled, then re-evaluated every stalled cycle.
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    case (state)
      IDLE:          if (sel_hit && !apb.enable) state_nxt = SETUP;
      SETUP, ACCESS: begin
        if (!sel_hit) state_nxt = IDLE;
        else if (apb.enable) begin
          ready_c   = !stall;
          state_nxt = stall ? ACCESS : IDLE;
        end
      end
      default:       state_nxt = IDLE;
    endcase
  end

  assign xfer      = ready_c;
  assign apb.ready = ready_c;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state == IDLE && sel_hit && !apb.enable) begin
      addr_q  <= apb.addr;
      wr_q    <= apb.write;
      wdata_q <= apb.wdata;
    end

  // ---------------- TX FIFO ----------------
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rp];
  assign tx_push  = xfer && is_tx_wr;     // stall guarantees room
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_cnt_d = tx_cnt + {{PW{1'b0}}, tx_push} - {{PW{1'b0}}, tx_pop};

  always_ff @(posedge clk) if (tx_push) tx_mem[tx_wp] <= wdata_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt_d;
    end

  // ---------------- RX FIFO ----------------
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_rd    = xfer && !wr_q && (addr_q == A_RXDATA);
  assign rx_pop   = rx_rd && !rx_empty;
  // a pop on the same edge frees the slot for an incoming byte
  assign rx_push  = rx_valid && (!rx_full || rx_pop);
  assign rx_cnt_d = rx_cnt + {{PW{1'b0}}, rx_push} - {{PW{1'b0}}, rx_pop};

  always_ff @(posedge clk) if (rx_push) rx_mem[rx_wp] <= rx_data;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt_d;
    end

  // ---------------- sticky status (set beats W1C) ----------------
  assign sts_wr   = xfer && wr_q && (addr_q == A_STATUS);
  assign rx_unf_d = (rx_rd && rx_empty) || (rx_unf && !(sts_wr && wdata_q[5]));
  assign nack_d   = nack || (nack_seen && !(sts_wr && wdata_q[6]));
  assign rx_ovf_d = (rx_valid && rx_full && !rx_pop) || (rx_ovf && !(sts_wr && wdata_q[7]));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_unf <= 1'b0; nack_seen <= 1'b0; rx_ovf <= 1'b0;
    end else begin
      rx_unf <= rx_unf_d; nack_seen <= nack_d; rx_ovf <= rx_ovf_d;
    end

  // ---------------- SADDR + command ----------------
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      saddr     <= '0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_rw    <= 1'b0;
      cmd_len   <= '0;
      busy      <= 1'b0;
    end else begin
      if (xfer && wr_q && addr_q == A_SADDR) saddr <= wdata_q[7:0];
      if (xfer && is_cmd_wr) begin
        cmd_valid <= 1'b1;
        cmd_addr  <= saddr[6:0];
        cmd_rw    <= saddr[7];
        cmd_len   <= wdata_q[3:0];
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      // done while idle is ignored
      busy <= (cmd_valid && cmd_ready) || (busy && !done);
    end

`ifdef APB_I2C_IRQ_EN
  logic [2:0] ier;
  logic       done_flag, done_flag_d;
  assign done_flag_d = (done && busy) || (done_flag && !(sts_wr && wdata_q[4]));

  // irq registers the post-edge view of the sources so it follows them by one edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ier <= '0; done_flag <= 1'b0; irq <= 1'b0;
    end else begin
      if (xfer && wr_q && addr_q == A_IER) ier <= wdata_q[2:0];
      done_flag <= done_flag_d;
      irq <= (done_flag_d && ier[0]) || (nack_d && ier[1]) ||
             ((rx_cnt_d != '0) && ier[2]);
    end
`endif

  // ---------------- read mux ----------------
  always_comb begin
    rd_val = '0;
    case (addr_q)
      A_SADDR:  rd_val = DATA_W'(saddr);
      A_RXDATA: if (!rx_empty) rd_val = rx_mem[rx_rp];
      A_STATUS: rd_val = DATA_W'({rx_ovf, nack_seen, rx_unf, busy,
                                  rx_empty, rx_full, tx_empty, tx_full});
`ifdef APB_I2C_IRQ_EN
      A_IER:    rd_val = DATA_W'(ier);
`endif
      default:  rd_val = '0;
    endcase
  end

  assign apb.rdata = (ready_c && !wr_q) ? rd_val : '0;

endmodule

// File: tb/tb_apb_i2c_regs.sv
module tb_apb_i2c_regs;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_rw, tx_valid, tx_ready, rx_valid, done, nack;
  logic [6:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] tx_data, rx_data;
`ifdef APB_I2C_IRQ_EN
  logic       irq;
`endif

  apb_i2c_regs_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_i2c_regs dut (
    .clk(clk), .reset_n(reset_n), .apb(bus),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .nack(nack)
`ifdef APB_I2C_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apb_start(input logic w, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.sel = 2'b01; bus.enable = 1'b0; bus.write = w; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.enable = 1'b1;
  endtask

  // waits = negedges seen with ready low in the access phase
  task automatic apb_finish(output logic [7:0] rd, output int waits);
    waits = 0;
    @(negedge clk);
    while (!bus.ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.ready) chk("apb_timeout", 0, 1);
    rd = bus.rdata;
    @(posedge clk); #1;
    bus.sel = 2'b00; bus.enable = 1'b0;
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd; int w;
    apb_start(1'b1, a, d);
    apb_finish(rd, w);
  endtask

  task automatic apb_rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    logic [7:0] rd; int w;
    apb_start(1'b0, a, 8'h00);
    apb_finish(rd, w);
    chk(nm, rd, exp);
  endtask

  task automatic cyc_pulse(input int which);   // 0 tx_ready 1 cmd_ready 2 done 3 nack
    @(posedge clk); #1;
    case (which)
      0: tx_ready = 1'b1; 1: cmd_ready = 1'b1; 2: done = 1'b1; default: nack = 1'b1;
    endcase
    @(posedge clk); #1;
    tx_ready = 1'b0; cmd_ready = 1'b0; done = 1'b0; nack = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    string      name;
  } vec_t;

  localparam logic [7:0] SADDR = 8'h0, TXD = 8'h1, RXD = 8'h2, STS = 8'h3, CMD = 8'h4;

  initial begin
    vec_t vecs[9];
    logic [7:0] rd;
    int w;

    vecs[0] = '{1'b0, STS,   8'h00, 8'h0A, "status_after_reset"};
    vecs[1] = '{1'b1, SADDR, 8'h51, 8'h00, "saddr_wr"};
    vecs[2] = '{1'b0, SADDR, 8'h00, 8'h51, "saddr_rd"};
    vecs[3] = '{1'b0, TXD,   8'h00, 8'h00, "txdata_rd_zero"};
    vecs[4] = '{1'b1, 8'h07, 8'h33, 8'h00, "unmapped_wr"};
    vecs[5] = '{1'b0, 8'h07, 8'h00, 8'h00, "unmapped_rd"};
    vecs[6] = '{1'b0, 8'h05, 8'h00, 8'h00, "addr5_rd"};
    vecs[7] = '{1'b1, CMD,   8'h00, 8'h00, "cmd_len0_wr"};
    vecs[8] = '{1'b0, STS,   8'h00, 8'h0A, "status_after_len0"};

    reset_n = 1'b0;
    bus.sel = 2'b00; bus.enable = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
    cmd_ready = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; done = 1'b0; nack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.ready, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_tx_valid", tx_valid, 0);
    reset_n = 1'b1;

    // table: zero-wait register accesses
    foreach (vecs[i]) begin
      apb_start(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      apb_finish(rd, w);
      chk({vecs[i].name, "_waits"}, w, 0);
      if (!vecs[i].wr) chk(vecs[i].name, rd, vecs[i].exp_rd);
    end
    chk("len0_no_cmd", cmd_valid, 0);

    // TX full stall
    for (int i = 0; i < 4; i++) apb_wr(TXD, 8'hA0 + 8'(i));
    apb_start(1'b1, TXD, 8'hA4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("tx_full_stall", bus.ready, 0);
    end
    cyc_pulse(0);
    apb_finish(rd, w);
    chk("tx_head_after_pop", tx_data, 8'hA1);
    apb_rd(STS, 8'h09, "status_tx_full");
    @(posedge clk); #1 tx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 tx_ready = 1'b0;
    chk("tx_drained", tx_valid, 0);

    // command issue, then CMD stall while busy
    apb_wr(SADDR, 8'hA2);
    apb_wr(CMD, 8'h03);
    chk("cmd_valid", cmd_valid, 1);
    chk("cmd_addr", cmd_addr, 7'h22);
    chk("cmd_rw", cmd_rw, 1);
    chk("cmd_len", cmd_len, 3);
    cyc_pulse(1);
    chk("cmd_valid_drop", cmd_valid, 0);
    apb_rd(STS, 8'h1A, "status_busy");
    apb_start(1'b1, CMD, 8'h05);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("cmd_busy_stall", bus.ready, 0);
    end
    cyc_pulse(2);
    apb_finish(rd, w);
    chk("cmd2_valid", cmd_valid, 1);
    chk("cmd2_len", cmd_len, 5);
    cyc_pulse(1);
    cyc_pulse(2);
    apb_rd(STS, 8'h0A, "status_idle");

    // RX overflow / underflow / W1C
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h10 + 8'(i);
    end
    @(posedge clk); #1 rx_valid = 1'b0;
    apb_rd(STS, 8'h86, "status_rx_ovf");
    for (int i = 0; i < 4; i++) apb_rd(RXD, 8'h10 + 8'(i), "rx_byte");
    apb_rd(RXD, 8'h00, "rx_underflow_rd");
    apb_rd(STS, 8'hAA, "status_unf_ovf");
    apb_wr(STS, 8'hE0);
    apb_rd(STS, 8'h0A, "status_w1c");

    // RX full: pop and push on the same edge
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h20 + 8'(i);
    end
    @(posedge clk); #1 rx_valid = 1'b0;
    apb_start(1'b0, RXD, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h24;
    apb_finish(rd, w);
    rx_valid = 1'b0;
    chk("rx_pop_push_data", rd, 8'h20);
    apb_rd(STS, 8'h06, "status_full_no_ovf");

    // nack set vs W1C
    cyc_pulse(3);
    apb_start(1'b1, STS, 8'h40);
    nack = 1'b1;
    apb_finish(rd, w);
    nack = 1'b0;
    apb_rd(STS, 8'h46, "nack_set_wins");
    apb_wr(STS, 8'h40);
    apb_rd(STS, 8'h06, "nack_w1c");

    // reset during a CMD stall
    apb_wr(TXD, 8'h55);
    apb_wr(CMD, 8'h01);
    apb_start(1'b1, CMD, 8'h02);
    @(negedge clk);
    chk("cmd_pending_stall", bus.ready, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", bus.ready, 0);
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_tx_valid", tx_valid, 0);
    bus.sel = 2'b00; bus.enable = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    apb_rd(STS, 8'h0A, "status_post_rst");
    apb_rd(SADDR, 8'h00, "saddr_post_rst");

`ifdef APB_I2C_IRQ_EN
    apb_wr(8'h05, 8'h01);
    apb_rd(8'h05, 8'h01, "ier_rd");
    apb_wr(CMD, 8'h01);
    cyc_pulse(1);
    chk("irq_before_done", irq, 0);
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    chk("irq_after_done", irq, 1);
    apb_wr(STS, 8'h10);
    chk("irq_cleared", irq, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
